// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, hazard FSM encoding and field decode.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned REG_W   = 5;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Destination register written by an instruction: rd for R-type, rt otherwise.
    function automatic logic [REG_W-1:0] dest_reg(input logic [INSTR_W-1:0] x);
        return (x[31:26] == OP_RTYPE) ? x[15:11] : x[20:16];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use / branch-operand stalls, control-flow flushes,
// and saturating stall/flush performance counters.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned PERF_W = 32,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       id_instru,
    input  logic [31:0]       ex_instru,
    input  logic [31:0]       mem_instru,
    input  logic              ex_MemRead,
    input  logic              ex_RegWrite,
    input  logic              mem_MemRead,
    input  logic              id_br_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_cycles
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OPC_W-1:0] id_op;
    logic [REG_W-1:0] id_rs, id_rt, ex_dest, mem_dest;
    logic             id_uses_rt, id_is_br, id_is_jmp;
    logic             ex_hit, mem_hit;
    logic [1:0]       need;

    assign id_op      = id_instru[31:26];
    assign id_rs      = id_instru[25:21];
    assign id_rt      = id_instru[20:16];
    assign ex_dest    = dest_reg(ex_instru);
    assign mem_dest   = dest_reg(mem_instru);
    assign id_is_br   = (id_op == OP_BEQ) || (id_op == OP_BNE);
    assign id_is_jmp  = (id_op == OP_J) || (id_op == OP_JAL);
    assign id_uses_rt = (id_op == OP_RTYPE) || id_is_br || (id_op == OP_SW);

    // $zero is never a real dependency.
    assign ex_hit  = (ex_dest != '0) &&
                     ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    assign mem_hit = (mem_dest != '0) &&
                     ((mem_dest == id_rs) || (id_uses_rt && (mem_dest == id_rt)));

    always_comb begin
        need = 2'd0;
        if (id_is_br && ex_MemRead && ex_hit) begin
            need = 2'd2;
        end else if ((ex_MemRead && ex_hit) ||
                     (id_is_br && ex_RegWrite && ex_hit) ||
                     (id_is_br && mem_MemRead && mem_hit)) begin
            need = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall outputs are Mealy in RUN; STALL holds them until the latched count expires.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (need != 2'd0) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (need == 2'd2) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_W'(1);
                    end
                end else if ((id_is_br && id_br_taken) || id_is_jmp) begin
                    if_id_flush = 1'b1;
                end
            end
            ST_STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == ST_STALL);

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (id_ex_bubble),
        .count_o (stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (if_id_flush),
        .count_o (flush_cycles)
    );

    // Only opcode and register fields are decoded.
    logic unused_fields;
    assign unused_fields = ^{id_instru[15:0], ex_instru, mem_instru};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int unsigned PERF_W = 6;
    localparam int          CMAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       id_instru, ex_instru, mem_instru;
    logic              ex_MemRead, ex_RegWrite, mem_MemRead, id_br_taken;
    logic              pc_write, if_id_write, id_ex_bubble, if_id_flush, busy;
    logic [PERF_W-1:0] stall_cycles, flush_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_owed = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    hazard_stall_ctrl #(.PERF_W(PERF_W), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_instru    (id_instru),
        .ex_instru    (ex_instru),
        .mem_instru   (mem_instru),
        .ex_MemRead   (ex_MemRead),
        .ex_RegWrite  (ex_RegWrite),
        .mem_MemRead  (mem_MemRead),
        .id_br_taken  (id_br_taken),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_add(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_fmt(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] j_fmt(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic int dst(input logic [31:0] x);
        return (x[31:26] == 6'h00) ? int'(x[15:11]) : int'(x[20:16]);
    endfunction

    // Extra cycles the ID instruction must wait, straight from the hazard rules.
    function automatic int need_of(input logic [31:0] id, input logic [31:0] ex,
                                   input logic [31:0] mem, input logic exm,
                                   input logic exw, input logic memm);
        int  op, rs, rt, de, dm;
        bit  use_rt, br, he, hm;
        op     = int'(id[31:26]);
        rs     = int'(id[25:21]);
        rt     = int'(id[20:16]);
        br     = (op == 4) || (op == 5);
        use_rt = (op == 0) || br || (op == 'h2B);
        de     = dst(ex);
        dm     = dst(mem);
        he     = (de != 0) && ((de == rs) || (use_rt && de == rt));
        hm     = (dm != 0) && ((dm == rs) || (use_rt && dm == rt));
        if (br && exm && he) return 2;
        if ((exm && he) || (br && exw && he) || (br && memm && hm)) return 1;
        return 0;
    endfunction

    // Drive one cycle, compare mid-cycle, then advance the model over the edge.
    task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                        input logic exm, input logic exw, input logic memm,
                        input logic br, input logic rstn);
        int n, op;
        bit e_bub, e_flush;
        id_instru   = id;
        ex_instru   = ex;
        mem_instru  = mem;
        ex_MemRead  = exm;
        ex_RegWrite = exw;
        mem_MemRead = memm;
        id_br_taken = br;
        rst_n       = rstn;
        #3;
        op      = int'(id[31:26]);
        n       = (m_owed > 0) ? 0 : need_of(id, ex, mem, exm, exw, memm);
        e_bub   = (m_owed > 0) || (n > 0);
        e_flush = !e_bub && ((((op == 4) || (op == 5)) && br) || (op == 2) || (op == 3));
        check_eq("pc_write",     32'(pc_write),     32'(!e_bub));
        check_eq("if_id_write",  32'(if_id_write),  32'(!e_bub));
        check_eq("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
        check_eq("if_id_flush",  32'(if_id_flush),  32'(e_flush));
        check_eq("busy",         32'(busy),         32'(m_owed > 0));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        check_eq("flush_cycles", 32'(flush_cycles), 32'(m_fc));
        if (!rstn) begin
            m_owed = 0;
            m_sc   = 0;
            m_fc   = 0;
        end else begin
            if (e_bub && m_sc < CMAX) m_sc++;
            if (e_flush && m_fc < CMAX) m_fc++;
            m_owed = (m_owed > 0) ? m_owed - 1 : ((n == 2) ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    localparam int T0 = 8, T1 = 9, T2 = 10, S0 = 16;

    logic [31:0] nop, lw_t0, add_t0;
    logic [5:0]  ops[8];

    initial begin
        nop    = 32'h0;
        lw_t0  = i_fmt(6'h23, S0, T0);
        add_t0 = r_add(T0, T1, T2);
        ops    = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08};

        rst_n = 1'b0; id_instru = '0; ex_instru = '0; mem_instru = '0;
        ex_MemRead = 0; ex_RegWrite = 0; mem_MemRead = 0; id_br_taken = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset state, no hazard
        step(nop, nop, nop, 0, 0, 0, 0, 1);

        // load-use: one bubble
        step(r_add(T1, T0, T2), lw_t0, nop, 1, 1, 0, 0, 1);
        step(r_add(T1, T0, T2), nop, lw_t0, 0, 0, 1, 0, 1);
        check_eq("t1_stall_cycles", 32'(stall_cycles), 32'd1);

        // beq after lw: two bubbles, then flush on taken
        step(i_fmt(6'h04, T0, T1), lw_t0, nop, 1, 1, 0, 1, 1);
        step(i_fmt(6'h04, T0, T1), nop, lw_t0, 0, 0, 1, 1, 1);
        step(i_fmt(6'h04, T0, T1), nop, nop, 0, 0, 0, 1, 1);
        check_eq("t2_stall_cycles", 32'(stall_cycles), 32'd3);

        // bne after ALU op: one bubble then flush
        step(i_fmt(6'h05, T0, 0), add_t0, nop, 0, 1, 0, 1, 1);
        step(i_fmt(6'h05, T0, 0), nop, add_t0, 0, 0, 0, 1, 1);

        // jump flushes with no stall
        step(j_fmt(6'h02, 26'h100), nop, nop, 0, 0, 0, 0, 1);

        // $zero never matches; sw data register does
        step(r_add(T1, 0, 0), i_fmt(6'h23, S0, 0), nop, 1, 1, 0, 0, 1);
        step(i_fmt(6'h2B, S0, T0), lw_t0, nop, 1, 1, 0, 0, 1);
        step(i_fmt(6'h2B, S0, T0), nop, lw_t0, 0, 0, 1, 0, 1);

        // reset during STALL abandons the pending bubble
        step(i_fmt(6'h04, T0, T1), lw_t0, nop, 1, 1, 0, 0, 1);
        step(i_fmt(6'h04, T0, T1), nop, lw_t0, 0, 0, 1, 0, 0);
        check_eq("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check_eq("rst_flush_cycles", 32'(flush_cycles), 32'd0);
        step(nop, nop, nop, 0, 0, 0, 0, 1);

        // drive the stall counter into saturation
        repeat (CMAX + 6) step(r_add(T1, T0, T2), lw_t0, nop, 1, 1, 0, 0, 1);
        check_eq("sat_stall_cycles", 32'(stall_cycles), 32'(CMAX));
        step(r_add(T1, T0, T2), lw_t0, nop, 1, 1, 0, 0, 1);

        // randomized traffic on a small register set to provoke matches
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w[3];
            for (int k = 0; k < 3; k++) begin
                logic [5:0] op;
                op = ops[$urandom_range(0, 7)];
                if (op == 6'h00)
                    w[k] = r_add(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                 int'($urandom_range(0, 3)));
                else if (op == 6'h02 || op == 6'h03)
                    w[k] = {op, 26'($urandom)};
                else
                    w[k] = i_fmt(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            step(w[0], w[1], w[2], 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 59) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
